// File: rtl/ram_boot_loader.sv
// Boot-time RAM preloader: parses a big-endian 16-bit word-count header from a byte
// stream, then writes big-endian 16-bit words to consecutive RAM addresses from BASE_ADDR.
module ram_boot_loader #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] HDR_HI = 4'd1;
  localparam logic [3:0] HDR_LO = 4'd2;
  localparam logic [3:0] CHECK  = 4'd3;
  localparam logic [3:0] DAT_HI = 4'd4;
  localparam logic [3:0] DAT_LO = 4'd5;
  localparam logic [3:0] WRITE  = 4'd6;
  localparam logic [3:0] DONE   = 4'd7;
  localparam logic [3:0] ERR    = 4'd8;

  // Largest legal word count: fills RAM exactly from BASE_ADDR to the top.
  localparam logic [32:0] MAX_N = 33'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

  logic [3:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              err_q, err_d;
  logic              rdy_q, load_q, busy_q, done_q;
  logic              accept;

  assign accept = byte_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HDR_HI;
        err_d   = 1'b0;
        idx_d   = '0;
      end
      HDR_HI: if (accept) begin
        n_d[15:8] = byte_in;
        state_d   = HDR_LO;
      end
      HDR_LO: if (accept) begin
        n_d[7:0] = byte_in;
        state_d  = CHECK;
      end
      CHECK: begin
        if (33'(n_q) > MAX_N) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (n_q == 16'd0) begin
          state_d = DONE;
        end else begin
          state_d = DAT_HI;
        end
      end
      DAT_HI: if (accept) begin
        hi_d    = byte_in;
        state_d = DAT_LO;
      end
      DAT_LO: if (accept) begin
        // Data and address are latched here so they are stable for the whole WRITE cycle.
        wdata_d = DATA_W'({hi_q, byte_in});
        waddr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = (17'(idx_q) + 17'd1 == 17'(n_q)) ? DONE : DAT_HI;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
      // Status outputs are decoded from the next state so they are glitch-free flops.
      rdy_q   <= (state_d == HDR_HI) || (state_d == HDR_LO) ||
                 (state_d == DAT_HI) || (state_d == DAT_LO);
      load_q  <= (state_d == WRITE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign byte_ready  = rdy_q;
  assign ram_in      = wdata_q;
  assign ram_address = waddr_q;
  assign ram_load    = load_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed bench for ram_boot_loader: expected RAM writes go into a scoreboard queue as
// bytes are driven and are popped by a monitor whenever ram_load is seen.
module tb_ram_boot_loader;
  localparam int ADDR_W = 14;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic [15:0]       ram_in;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_load, busy, done, error;

  ram_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(16), .BASE_ADDR(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .ram_in(ram_in),
    .ram_address(ram_address), .ram_load(ram_load), .busy(busy),
    .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0, done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_addr;
  logic [31:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST_N && ram_load) begin
      wr_cnt++;
      last_addr = 32'(ram_address);
      if (exp_q.size() == 0) chk("unexpected_write", 32'(ram_address), 32'hFFFF_FFFF);
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_address), 32'(e[31:16]));
        chk("wr_data", 32'(ram_in), 32'(e[15:0]));
      end
    end
    if (RST_N && done) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  k = 0;
    bit  acc = 0;
    while (!acc && k < 200) begin
      @(negedge CLK); k++;
      byte_in    = b;
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (byte_valid && byte_ready) acc = 1;
    end
    if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w, input bit rnd);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 16'd1;
    send_byte(w[15:8], rnd);
    send_byte(w[7:0], rnd);
  endtask

  task automatic do_start();
    @(negedge CLK); byte_valid = 1'b0; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    exp_addr = 16'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge CLK); byte_valid = 1'b0;
    while (busy && k < 100) begin @(negedge CLK); k++; end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int wr0, dn0;
    // Reset state
    #12;
    chk("rst_ready", 32'(byte_ready), 0); chk("rst_load", 32'(ram_load), 0);
    chk("rst_busy", 32'(busy), 0);        chk("rst_error", 32'(error), 0);
    chk("rst_in", 32'(ram_in), 0);        chk("rst_addr", 32'(ram_address), 0);
    @(negedge CLK); RST_N = 1'b1;
    // Bytes offered in IDLE must not be consumed
    @(negedge CLK); byte_in = 8'hFF; byte_valid = 1'b1;
    @(negedge CLK); chk("idle_ready", 32'(byte_ready), 0);

    // Test 1: three words, explicit latency check on the last one
    wr0 = wr_cnt; dn0 = done_cnt;
    do_start();
    chk("busy_after_start", 32'(busy), 1);
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_word(16'h1234, 0); send_word(16'hABCD, 0); send_word(16'h8001, 0);
    @(negedge CLK); byte_valid = 1'b0;
    chk("load_latency", 32'(ram_load), 1);
    wait_idle();
    chk("t1_writes", 32'(wr_cnt - wr0), 3);
    chk("t1_done", 32'(done_cnt - dn0), 1);
    chk("t1_sb_empty", 32'(exp_q.size()), 0);

    // Test 2: same stream with random valid gaps
    wr0 = wr_cnt; dn0 = done_cnt;
    do_start();
    send_byte(8'h00, 1); send_byte(8'h03, 1);
    send_word(16'h1234, 1); send_word(16'hABCD, 1); send_word(16'h8001, 1);
    wait_idle();
    chk("t2_writes", 32'(wr_cnt - wr0), 3);
    chk("t2_done", 32'(done_cnt - dn0), 1);

    // Test 3: empty load
    wr0 = wr_cnt; dn0 = done_cnt;
    do_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_idle();
    chk("t3_writes", 32'(wr_cnt - wr0), 0);
    chk("t3_done", 32'(done_cnt - dn0), 1);

    // Test 4a: one word too many for the RAM
    wr0 = wr_cnt; dn0 = done_cnt;
    do_start();
    send_byte(8'h40, 0); send_byte(8'h01, 0);
    wait_idle();
    chk("t4_error", 32'(error), 1);
    chk("t4_writes", 32'(wr_cnt - wr0), 0);
    chk("t4_done", 32'(done_cnt - dn0), 0);
    do_start();
    chk("t4_error_cleared", 32'(error), 0);

    // Test 4b: full RAM from the same start, last write at the top address
    wr0 = wr_cnt;
    send_byte(8'h40, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 16384; i++) send_word(16'(i) ^ 16'hA5C3, 0);
    wait_idle();
    chk("t4_full_writes", 32'(wr_cnt - wr0), 16384);
    chk("t4_last_addr", last_addr, 32'h3FFF);
    chk("t4_full_error", 32'(error), 0);

    // Test 5: reset after the high byte of the third word
    wr0 = wr_cnt;
    do_start();
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_word(16'h1234, 0); send_word(16'hABCD, 0);
    send_byte(8'h80, 0);
    @(negedge CLK); byte_valid = 1'b0; RST_N = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 0);   chk("t5_rst_ready", 32'(byte_ready), 0);
    chk("t5_rst_load", 32'(ram_load), 0); chk("t5_rst_addr", 32'(ram_address), 0);
    chk("t5_rst_in", 32'(ram_in), 0);
    chk("t5_writes", 32'(wr_cnt - wr0), 2);
    @(negedge CLK); RST_N = 1'b1;
    do_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(16'h5555, 0);
    wait_idle();
    chk("t5_reload_writes", 32'(wr_cnt - wr0), 3);

    // Test 6: start pulsed while waiting in DAT_LO is ignored
    wr0 = wr_cnt; dn0 = done_cnt;
    do_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    exp_q.push_back({16'd0, 16'hC0DE});
    exp_q.push_back({16'd1, 16'hBEEF});
    send_byte(8'hC0, 0);
    @(negedge CLK); byte_valid = 1'b0; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    chk("t6_busy", 32'(busy), 1);
    send_byte(8'hDE, 0);
    send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    wait_idle();
    chk("t6_writes", 32'(wr_cnt - wr0), 2);
    chk("t6_done", 32'(done_cnt - dn0), 1);
    chk("final_sb_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
